mem_port_rr_arbiter: RTL

Round-robin arbiter that shares the single data-memory port among 16 load/store requesters and sequences each transaction. It picks a winner with the ps16 priority selectors and holds the port until the memory side signals completion. Fairness comes from a rotating priority pointer. It sits between the load/store queue entries and the D-cache/memory request port.

---
 rtl/mem_port_rr_arbiter_pkg.sv | 22 ++
 rtl/mem_port_rr_arbiter_ps16.sv | 21 ++
 rtl/mem_port_rr_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_port_rr_arbiter_pkg.sv
// Shared types and helpers for the data-memory port round-robin arbiter.
package mem_port_rr_arbiter_pkg;

    localparam int ARB_N_REQ = 16;
    localparam int ARB_IDX_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_WAIT
    } arb_state_t;

    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N_REQ-1:0] onehot);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_N_REQ; i++) begin
            if (onehot[i]) idx = ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_port_rr_arbiter_ps16.sv
// 16-input priority selector: one-hot output at the highest set request index.
module ps16 (
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic        valid
);

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (en && req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory port among 16 load/store requesters.
// Define ARB_STARVE_EN to add per-requester wait counters with a starvation override.
module mem_port_rr_arbiter
    import mem_port_rr_arbiter_pkg::*;
#(
    parameter int N_REQ        = 16,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic                 port_ready,
    input  logic                 port_done,
    input  logic                 squash,
    output logic [N_REQ-1:0]     gnt,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 busy,
    output logic                 starve_flag
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must lie in 1..15");
    end

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [ARB_IDX_W-1:0] ptr_q;
    logic [ARB_N_REQ-1:0] gnt_q;
    logic [ARB_IDX_W-1:0] gnt_idx_q;
    logic                 busy_q;
    logic                 starve_q;

    logic [ARB_N_REQ-1:0] mask;
    logic [ARB_N_REQ-1:0] masked_req;
    logic [ARB_N_REQ-1:0] masked_gnt;
    logic [ARB_N_REQ-1:0] full_gnt;
    logic [ARB_N_REQ-1:0] win_onehot;
    logic [ARB_IDX_W-1:0] win_idx;
    logic                 masked_valid;
    logic                 full_valid;
    logic                 starve_pick;
    logic [ARB_N_REQ-1:0] starved_gnt;
    logic                 grant_now;
    logic                 complete;

    // Only indices below the last winner stay eligible first, so priority rotates downward.
    assign mask       = (ARB_N_REQ'(1) << ptr_q) - ARB_N_REQ'(1);
    assign masked_req = req & mask;
    assign complete   = port_done | squash;

    ps16 u_ps_masked (
        .en    (1'b1),
        .req   (masked_req),
        .gnt   (masked_gnt),
        .valid (masked_valid)
    );

    ps16 u_ps_full (
        .en    (1'b1),
        .req   (req),
        .gnt   (full_gnt),
        .valid (full_valid)
    );

`ifdef ARB_STARVE_EN
    localparam logic [ARB_IDX_W-1:0] STARVE_CAP = ARB_IDX_W'(STARVE_LIMIT);

    logic [ARB_IDX_W-1:0] wait_cnt [ARB_N_REQ];
    logic [ARB_N_REQ-1:0] starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < ARB_N_REQ; i++) begin
            starved[i] = req[i] && (wait_cnt[i] == STARVE_CAP);
        end
    end

    ps16 u_ps_starved (
        .en    (1'b1),
        .req   (starved),
        .gnt   (starved_gnt),
        .valid (starve_pick)
    );

    always_ff @(posedge clock) begin
        for (int i = 0; i < ARB_N_REQ; i++) begin
            if (reset || !req[i] || (grant_now && win_onehot[i])) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != STARVE_CAP) begin
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign starve_pick = 1'b0;
    assign starved_gnt = '0;
`endif

    always_comb begin
        if (starve_pick) begin
            win_onehot = starved_gnt;
        end else if (masked_valid) begin
            win_onehot = masked_gnt;
        end else begin
            win_onehot = full_gnt;
        end
        win_idx = onehot_to_idx(win_onehot);
    end

    always_comb begin
        state_d   = state_q;
        grant_now = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (full_valid && port_ready && !squash) begin
                    grant_now = 1'b1;
                    state_d   = ARB_GRANT;
                end
            end
            ARB_GRANT: state_d = complete ? ARB_IDLE : ARB_WAIT;
            ARB_WAIT:  if (complete) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            busy_q    <= 1'b0;
            starve_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ARB_IDLE);
            gnt_q   <= grant_now ? win_onehot : '0;
            if (grant_now) begin
                ptr_q     <= win_idx;
                gnt_idx_q <= win_idx;
                starve_q  <= starve_pick;
            end
        end
    end

    assign gnt         = gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign busy        = busy_q;
    assign starve_flag = starve_q;

endmodule
